uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small circular-buffer FIFO.
// A byte pushed into an empty, idle block starts its start bit on the next clock edge.
module uart_tx_fifo #(
   parameter int unsigned BAUD_DIV = 2604,
   parameter int unsigned DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] tx_byte,
   output logic       TX,
   output logic       full,
   output logic       empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       ovf
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [11:0] BaudMax   = 12'(BAUD_DIV - 1);
   localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

   typedef enum logic {StIdle, StXmit} state_e;

   state_e        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, empty_q;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [11:0]   baud_cnt_q, baud_cnt_d;
   logic          done_q, done_d, ovf_q, ovf_d;
   logic          frame_end, pop, push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         shift_q    <= '1;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= (count_d == CountFull);
         empty_q    <= (count_d == '0);
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_byte;
      end
   end

   always_comb begin
      frame_end = (state_q == StXmit) && (baud_cnt_q == '0) && (bit_cnt_q == 4'd9);
      pop       = !empty_q && ((state_q == StIdle) || frame_end);
      // A full FIFO still accepts a push when a pop frees a slot on the same edge.
      push      = wr_en && (!full_q || pop);
      ovf_d     = wr_en && full_q && !pop;
      done_d    = frame_end;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      baud_cnt_d = baud_cnt_q;
      if (pop) begin
         state_d    = StXmit;
         shift_d    = {1'b1, mem_q[rd_ptr_q], 1'b0};
         bit_cnt_d  = '0;
         baud_cnt_d = BaudMax;
      end else if (state_q == StXmit) begin
         if (baud_cnt_q == '0) begin
            shift_d = {1'b1, shift_q[9:1]};
            if (frame_end) begin
               state_d    = StIdle;
               bit_cnt_d  = '0;
               baud_cnt_d = '0;
            end else begin
               bit_cnt_d  = bit_cnt_q + 4'd1;
               baud_cnt_d = BaudMax;
            end
         end else begin
            baud_cnt_d = baud_cnt_q - 12'd1;
         end
      end
   end

   // The shift register LSB is the line itself; it idles at all-ones.
   always_comb begin
      TX      = shift_q[0];
      full    = full_q;
      empty   = empty_q;
      tx_busy = (state_q == StXmit);
      tx_done = done_q;
      ovf     = ovf_q;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a time-based FIFO/transmitter model predicts frames,
// pulses and status; independent monitors decode TX as a UART receiver and compare.
module tb_uart_tx_fifo;

   localparam int unsigned BAUD  = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FRAME = 10 * BAUD;

   typedef struct {
      logic [7:0]  data;
      int unsigned start_e;
   } frame_t;

   typedef struct {
      int unsigned edge_n;
      logic        full;
      logic        empty;
      logic        busy;
   } stat_t;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] tx_byte;
   logic       TX, full, empty, tx_busy, tx_done, ovf;

   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [7:0]  m_fifo[$];
   bit          m_active = 0;
   int unsigned m_end = 0;
   int unsigned m_drops = 0;
   int unsigned dut_ovf = 0;
   frame_t      exp_frames[$];
   int unsigned exp_done[$];
   int unsigned exp_ovf[$];
   stat_t       exp_stat[$];

   uart_tx_fifo #(.BAUD_DIV(BAUD), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .tx_byte (tx_byte),
      .TX      (TX),
      .full    (full),
      .empty   (empty),
      .tx_busy (tx_busy),
      .tx_done (tx_done),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event seen with nothing expected (edge %0d)", name, cyc);
   endtask

   // Predict the effect of the coming clock edge from the behavioural rules.
   task automatic model_step(input bit we, input logic [7:0] b);
      int unsigned e = cyc + 1;
      frame_t f;
      stat_t  st;
      if (m_active && m_end == e) begin
         exp_done.push_back(e);
         m_active = 0;
      end
      if (m_fifo.size() != 0 && !m_active) begin
         f.data    = m_fifo.pop_front();
         f.start_e = e;
         exp_frames.push_back(f);
         m_active  = 1;
         m_end     = e + FRAME;
      end
      if (we) begin
         if (m_fifo.size() < DEPTH) begin
            m_fifo.push_back(b);
         end else begin
            exp_ovf.push_back(e);
            m_drops++;
         end
      end
      st.edge_n = e;
      st.full   = (m_fifo.size() == DEPTH);
      st.empty  = (m_fifo.size() == 0);
      st.busy   = m_active;
      exp_stat.push_back(st);
   endtask

   task automatic step(input bit we, input logic [7:0] b);
      @(negedge clk);
      wr_en   = we;
      tx_byte = b;
      model_step(we, b);
   endtask

   // Push exactly on the edge where the running frame ends and the head is popped.
   task automatic push_on_pop(input logic [7:0] b);
      for (int k = 0; k < 4 * FRAME; k++) begin
         @(negedge clk);
         if (m_active && m_end == cyc + 1) begin
            wr_en = 1'b1;
            tx_byte = b;
            model_step(1'b1, b);
            return;
         end
         wr_en = 1'b0;
         model_step(1'b0, 8'h00);
      end
      check("push_on_pop_reached", 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 8 * FRAME && (m_fifo.size() != 0 || m_active); k++) step(1'b0, 8'h00);
      repeat (20) step(1'b0, 8'h00);
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      wr_en = 1'b0;
      m_fifo.delete();
      exp_frames.delete();
      exp_done.delete();
      exp_ovf.delete();
      exp_stat.delete();
      m_active = 0;
      #1;
      check("rst_tx", TX, 1);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_busy", tx_busy, 0);
      repeat (cycles) @(negedge clk);
      check("rst_hold_done", tx_done, 0);
      check("rst_hold_ovf", ovf, 0);
      #2;
      rst_n = 1'b1;
   endtask

   // UART receiver: every cycle of every bit must hold the level seen at its first cycle.
   bit          rx_active = 0;
   int unsigned rx_start, rx_pos, rx_glitch;
   logic [9:0]  rx_bits;
   frame_t      rx_exp;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         rx_active = 0;
      end else if (!rx_active) begin
         if (TX === 1'b0) begin
            rx_active  = 1;
            rx_start   = cyc;
            rx_bits    = '1;
            rx_bits[0] = 1'b0;
            rx_glitch  = 0;
         end
      end else begin
         rx_pos = cyc - rx_start;
         if (rx_pos % BAUD == 0) rx_bits[rx_pos / BAUD] = TX;
         else if (TX !== rx_bits[rx_pos / BAUD]) rx_glitch++;
         if (rx_pos == FRAME - 1) begin
            rx_active = 0;
            if (exp_frames.size() == 0) begin
               fail("unexpected_frame");
            end else begin
               rx_exp = exp_frames.pop_front();
               check("frame_start_edge", rx_start, rx_exp.start_e);
               check("frame_data", rx_bits[8:1], rx_exp.data);
               check("frame_start_stop", {rx_bits[9], rx_bits[0]}, 2'b10);
               check("frame_bit_hold", rx_glitch, 0);
            end
         end
      end
   end

   bit exp_d, exp_o;
   stat_t st_m;
   initial forever begin
      @(negedge clk);
      exp_d = (exp_done.size() != 0 && exp_done[0] == cyc);
      if (exp_d || tx_done !== 1'b0) begin
         if (exp_d) void'(exp_done.pop_front());
         check("tx_done_pulse", tx_done, exp_d);
      end
      exp_o = (exp_ovf.size() != 0 && exp_ovf[0] == cyc);
      if (ovf === 1'b1) dut_ovf++;
      if (exp_o || ovf !== 1'b0) begin
         if (exp_o) void'(exp_ovf.pop_front());
         check("ovf_pulse", ovf, exp_o);
      end
      if (exp_stat.size() != 0 && exp_stat[0].edge_n == cyc) begin
         st_m = exp_stat.pop_front();
         check("status_full_empty_busy", {full, empty, tx_busy}, {st_m.full, st_m.empty, st_m.busy});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got edge %0d, expected under 200000", cyc);
      $fatal(1);
   end

   int unsigned rate;
   initial begin
      wr_en   = 1'b0;
      tx_byte = 8'h00;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("init_tx", TX, 1);
      check("init_empty", empty, 1);
      check("init_full", full, 0);
      check("init_busy", tx_busy, 0);
      check("init_done", tx_done, 0);
      check("init_ovf", ovf, 0);
      #2 rst_n = 1'b1;

      // Single byte into idle block.
      step(1'b1, 8'hA5);
      drain();

      // Back-to-back frames.
      step(1'b1, 8'h00);
      step(1'b1, 8'hFF);
      step(1'b1, 8'h55);
      drain();

      // Six consecutive pushes: one popped, four stored, sixth dropped.
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i));
      // Full FIFO, push on the pop edge, repeated across pointer wrap.
      for (int i = 0; i < 6; i++) push_on_pop(8'(8'hC0 + i));
      drain();

      // Reset at clock 70 of a frame with two bytes queued.
      step(1'b1, 8'h3C);
      step(1'b1, 8'hC3);
      step(1'b1, 8'h99);
      for (int k = 0; k < FRAME && cyc + 1 < m_end - FRAME + 70; k++) step(1'b0, 8'h00);
      apply_reset(3);
      step(1'b1, 8'h5A);
      drain();

      // Randomized traffic.
      rate = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) rate = $urandom_range(100, 5);
         step($urandom_range(99) < rate, 8'($urandom));
      end
      step(1'b0, 8'h00);
      drain();

      check("frames_outstanding", exp_frames.size(), 0);
      check("tx_done_outstanding", exp_done.size(), 0);
      check("ovf_outstanding", exp_ovf.size(), 0);
      check("ovf_total", dut_ovf, m_drops);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
